// File: rtl/blowfish_pkg.sv
// rtl/blowfish_pkg.sv - shared state encoding and round constants for the Blowfish round controller
package blowfish_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } bf_state_e;

  localparam int BF_ROUNDS = 16;
  localparam int BF_P_LAST = 17;
  localparam int BF_BLOCKS = 2;
  localparam int BF_RND_W  = 4;
  localparam int BF_PIDX_W = 5;

endpackage

// File: rtl/bf_pidx_gen.sv
// rtl/bf_pidx_gen.sv - Feistel round counter and P-array index mapping
module bf_pidx_gen
  import blowfish_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode_q,
  input  logic                 clear,
  input  logic                 step,
  input  logic                 final_en,
  output logic [BF_RND_W-1:0]  rnd,
  output logic [BF_PIDX_W-1:0] p_idx,
  output logic                 last
);

  logic [BF_RND_W-1:0] rnd_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rnd_q <= '0;
    end else if (clear) begin
      rnd_q <= '0;
    end else if (step) begin
      rnd_q <= rnd_q + 1'b1;
    end
  end

  assign rnd  = rnd_q;
  assign last = (rnd_q == BF_RND_W'(BF_ROUNDS - 1));

  // Decrypt walks the P-array backwards, and whitens with P1/P0 instead of P16/P17.
  always_comb begin
    p_idx = '0;
    if (final_en) begin
      p_idx = mode_q ? BF_PIDX_W'(1) : BF_PIDX_W'(BF_ROUNDS);
    end else if (step) begin
      p_idx = mode_q ? (BF_PIDX_W'(BF_P_LAST) - {1'b0, rnd_q}) : {1'b0, rnd_q};
    end
  end

endmodule

// File: rtl/blowfish_round_ctrl.sv
// rtl/blowfish_round_ctrl.sv - sequences two 64-bit Blowfish blocks through load, 16 rounds, whitening and write-back
module blowfish_round_ctrl
  import blowfish_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic                 key_valid,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 blk_sel,
  output logic                 load,
  output logic                 round_en,
  output logic [BF_PIDX_W-1:0] p_idx,
  output logic                 final_en,
  output logic                 out_wr,
  output logic                 mode_q
);

  bf_state_e           state_q, state_d;
  logic                blk_sel_q, blk_sel_d;
  logic                mode_d;
  logic                st_round, st_final, cnt_clear, cnt_last;
  logic [BF_RND_W-1:0] rnd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      blk_sel_q <= 1'b0;
      mode_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      blk_sel_q <= blk_sel_d;
      mode_q    <= mode_d;
    end
  end

  // Abort overrides every transition; blk_sel returns to the upper half whenever we drop to IDLE.
  always_comb begin
    state_d   = state_q;
    blk_sel_d = blk_sel_q;
    mode_d    = mode_q;
    if (abort) begin
      state_d   = ST_IDLE;
      blk_sel_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && key_valid) begin
            state_d   = ST_LOAD;
            mode_d    = mode;
            blk_sel_d = 1'b0;
          end
        end
        ST_LOAD:  state_d = ST_ROUND;
        ST_ROUND: if (cnt_last) state_d = ST_FINAL;
        ST_FINAL: state_d = ST_WRITE;
        ST_WRITE: begin
          if (blk_sel_q == 1'(BF_BLOCKS - 1)) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_LOAD;
            blk_sel_d = blk_sel_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_d   = ST_IDLE;
          blk_sel_d = 1'b0;
        end
        default: begin
          state_d   = ST_IDLE;
          blk_sel_d = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    load     = (state_q == ST_LOAD);
    round_en = (state_q == ST_ROUND);
    final_en = (state_q == ST_FINAL);
    out_wr   = (state_q == ST_WRITE);
    done     = (state_q == ST_DONE);
    blk_sel  = blk_sel_q;
  end

  assign st_round  = (state_q == ST_ROUND);
  assign st_final  = (state_q == ST_FINAL);
  assign cnt_clear = (state_q == ST_IDLE) || (state_q == ST_LOAD);

  bf_pidx_gen u_pidx (
    .clk      (clk),
    .rst      (rst),
    .mode_q   (mode_q),
    .clear    (cnt_clear),
    .step     (st_round),
    .final_en (st_final),
    .rnd      (rnd),
    .p_idx    (p_idx),
    .last     (cnt_last)
  );

  a_last_matches_rnd: assert property (@(posedge clk) disable iff (!rst)
    cnt_last == (rnd == BF_RND_W'(BF_ROUNDS - 1)));

endmodule

// File: tb/tb_blowfish_round_ctrl.sv
// tb/tb_blowfish_round_ctrl.sv - randomized self-checking bench for blowfish_round_ctrl
module tb_blowfish_round_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, mode, key_valid, abort;
  logic       busy, done, blk_sel, load, round_en, final_en, out_wr, mode_q;
  logic [4:0] p_idx;

  int total = 0;
  int bad   = 0;
  bit last_m = 1'b0;

  wire [12:0] obs = {busy, done, blk_sel, load, round_en, p_idx, final_en, out_wr, mode_q};

  blowfish_round_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .key_valid (key_valid),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .blk_sel   (blk_sel),
    .load      (load),
    .round_en  (round_en),
    .p_idx     (p_idx),
    .final_en  (final_en),
    .out_wr    (out_wr),
    .mode_q    (mode_q)
  );

  always #5 clk = ~clk;

  // Expected outputs k cycles after the accepting edge (k = 0 or k >= 40 means idle).
  function automatic logic [12:0] model(input int k, input bit m);
    logic bsy, dn, bs, ld, re, fe, ow;
    logic [4:0] p;
    int j;
    {bsy, dn, bs, ld, re, fe, ow} = '0;
    p = '0;
    if (k >= 1 && k <= 39) begin
      bsy = 1'b1;
      bs  = (k >= 20);
      j   = (k <= 19) ? k : k - 19;
      if (k == 39) dn = 1'b1;
      else if (j == 1) ld = 1'b1;
      else if (j <= 17) begin
        re = 1'b1;
        p  = m ? 5'(17 - (j - 2)) : 5'(j - 2);
      end else if (j == 18) begin
        fe = 1'b1;
        p  = m ? 5'd1 : 5'd16;
      end else ow = 1'b1;
    end
    return {bsy, dn, bs, ld, re, p, fe, ow, m};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts one operation from an IDLE cycle and checks cycles 1..40 after acceptance.
  task automatic do_op(input bit m, input bit noise, input bit hold, input int abort_at, input string name);
    start = 1'b1; mode = m; key_valid = 1'b1; abort = 1'b0;
    step();
    last_m = m;
    for (int k = 1; k <= 40; k++) begin
      logic [12:0] e;
      e = (abort_at > 0 && k > abort_at) ? model(0, m) : model(k, m);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL %s cycle=%0d got=%h exp=%h", name, k, obs, e);
      end
      if (k == 40) break;
      abort = (k == abort_at);
      if (hold) begin
        start = 1'b1; key_valid = 1'b1;
      end else if (noise && abort_at == 0) begin
        start = 1'($urandom); mode = 1'($urandom); key_valid = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      step();
    end
    abort = 1'b0;
    if (!hold) start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; mode = 1'b0; key_valid = 1'b0; abort = 1'b0;
    #3;
    total++;
    if (obs !== 13'd0) begin bad++; $display("FAIL reset_async got=%h exp=%h", obs, 13'd0); end
    start = 1'b1; key_valid = 1'b1; mode = 1'b1;
    step(); step();
    total++;
    if (obs !== 13'd0) begin bad++; $display("FAIL reset_held got=%h exp=%h", obs, 13'd0); end
    @(negedge clk);
    rst = 1'b1; start = 1'b0; key_valid = 1'b0; mode = 1'b0;
  endtask

  task automatic test_encrypt();
    do_op(1'b0, 1'b1, 1'b0, 0, "encrypt");
  endtask

  task automatic test_decrypt();
    do_op(1'b1, 1'b1, 1'b0, 0, "decrypt");
  endtask

  task automatic test_random_ops();
    for (int i = 0; i < 3; i++) do_op(1'($urandom), 1'($urandom), 1'b0, 0, "random_op");
  endtask

  task automatic test_gating();
    start = 1'b1; key_valid = 1'b0; abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mode = 1'($urandom);
      step();
      total++;
      if (obs !== model(0, last_m)) begin
        bad++; $display("FAIL gating_idle got=%h exp=%h", obs, model(0, last_m));
      end
    end
    abort = 1'b1; key_valid = 1'b1;
    step();
    total++;
    if (obs !== model(0, last_m)) begin
      bad++; $display("FAIL abort_in_idle got=%h exp=%h", obs, model(0, last_m));
    end
    abort = 1'b0;
    do_op(1'($urandom), 1'b0, 1'b0, 0, "gating_release");
  endtask

  task automatic test_abort();
    do_op(1'($urandom), 1'b0, 1'b0, 25, "abort_25");
    do_op(1'($urandom), 1'b0, 1'b0, $urandom_range(1, 38), "abort_rand");
    do_op(1'b1, 1'b0, 1'b0, 0, "after_abort");
  endtask

  task automatic test_async_reset();
    bit m;
    m = 1'($urandom);
    start = 1'b1; mode = m; key_valid = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    total++;
    if (obs !== model(8, m)) begin bad++; $display("FAIL pre_reset got=%h exp=%h", obs, model(8, m)); end
    #2 rst = 1'b0;
    #1;
    total++;
    if (obs !== 13'd0) begin bad++; $display("FAIL async_reset got=%h exp=%h", obs, 13'd0); end
    @(negedge clk);
    rst = 1'b1;
    last_m = 1'b0;
    total++;
    if (obs !== model(0, 1'b0)) begin bad++; $display("FAIL post_release got=%h exp=%h", obs, model(0, 1'b0)); end
    do_op(~m, 1'b0, 1'b0, 0, "post_reset_op");
  endtask

  task automatic test_back_to_back();
    do_op(1'($urandom), 1'b0, 1'b1, 0, "b2b_first");
    do_op(1'($urandom), 1'b0, 1'b1, 0, "b2b_second");
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_random_ops();
    test_gating();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
